// File: rtl/cpu_run_controller.sv
// Run/load sequencer for the 5-bit single-cycle CPU: streams a program into the
// CPU's RAM, gates PC_Enable for run/step, and detects halt and PC breakpoints.
module cpu_run_controller #(
    parameter int DATA_W = 11,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              cmd_load_i,
    input  logic              cmd_run_i,
    input  logic              cmd_step_i,
    input  logic              cmd_stop_i,
    input  logic              ld_valid_i,
    input  logic [DATA_W-1:0] ld_data_i,
    output logic              ld_ready_o,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              bp_en_i,
    input  logic [ADDR_W-1:0] bp_addr_i,
    output logic              pc_enable_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_waddr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    output logic [2:0]        state_o,
    output logic              halted_o,
    output logic              bp_hit_o,
    output logic [CNT_W-1:0]  instr_cnt_o
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        STEP = 3'd3,
        HALT = 3'd4
    } state_t;

    state_t             state_q;
    logic [ADDR_W-1:0]  ld_cnt_q;
    logic [ADDR_W-1:0]  prev_pc_q;
    logic [ADDR_W-1:0]  ram_waddr_q;
    logic [DATA_W-1:0]  ram_wdata_q;
    logic               ram_we_q;
    logic               bp_hit_q;
    logic               en_d_q;
    logic               skip_bp_q;
    logic [CNT_W-1:0]   instr_cnt_q;

    logic               accept;
    logic               ld_last;
    logic               bp_match;
    logic               halt_det;
    logic               pc_enable;
    logic [CNT_W-1:0]   instr_cnt_inc;

    assign ld_ready_o    = (state_q == LOAD);
    assign accept        = ld_ready_o && ld_valid_i;
    assign ld_last       = (ld_cnt_q == ADDR_W'(DEPTH - 1));
    // skip_bp lets a run resumed at the breakpoint PC execute that instruction once
    assign bp_match      = bp_en_i && (pc_i == bp_addr_i) && !skip_bp_q;
    assign halt_det      = en_d_q && (pc_i == prev_pc_q);
    assign instr_cnt_inc = (instr_cnt_q == '1) ? instr_cnt_q : instr_cnt_q + CNT_W'(1);

    always_comb begin
        pc_enable = 1'b0;
        case (state_q)
            RUN:     pc_enable = !bp_match;
            STEP:    pc_enable = 1'b1;
            default: pc_enable = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            ld_cnt_q    <= '0;
            prev_pc_q   <= '0;
            ram_waddr_q <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            bp_hit_q    <= 1'b0;
            en_d_q      <= 1'b0;
            skip_bp_q   <= 1'b0;
            instr_cnt_q <= '0;
        end else begin
            ram_we_q <= 1'b0;
            en_d_q   <= 1'b0;
            // The write lands one cycle after its accept, even if stop arrives with it
            if (accept) begin
                ram_we_q    <= 1'b1;
                ram_waddr_q <= ld_cnt_q;
                ram_wdata_q <= ld_data_i;
                ld_cnt_q    <= ld_cnt_q + ADDR_W'(1);
            end
            case (state_q)
                IDLE, HALT: begin
                    if (cmd_stop_i) begin
                        state_q <= IDLE;
                    end else if (cmd_load_i) begin
                        state_q  <= LOAD;
                        ld_cnt_q <= '0;
                        bp_hit_q <= 1'b0;
                    end else if (cmd_run_i) begin
                        state_q     <= RUN;
                        bp_hit_q    <= 1'b0;
                        instr_cnt_q <= '0;
                        skip_bp_q   <= 1'b1;
                    end else if (cmd_step_i && state_q == IDLE) begin
                        state_q     <= STEP;
                        bp_hit_q    <= 1'b0;
                        instr_cnt_q <= '0;
                    end
                end
                LOAD: begin
                    if (cmd_stop_i || (accept && ld_last))
                        state_q <= IDLE;
                end
                RUN: begin
                    skip_bp_q <= 1'b0;
                    // The re-executed self-jump that reveals the halt is not counted
                    if (pc_enable && !halt_det) begin
                        prev_pc_q   <= pc_i;
                        en_d_q      <= 1'b1;
                        instr_cnt_q <= instr_cnt_inc;
                    end
                    if (cmd_stop_i) begin
                        state_q <= IDLE;
                    end else if (!pc_enable) begin
                        state_q  <= IDLE;
                        bp_hit_q <= 1'b1;
                    end else if (halt_det) begin
                        state_q <= HALT;
                    end
                end
                STEP: begin
                    instr_cnt_q <= instr_cnt_inc;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pc_enable_o = pc_enable;
    assign ram_we_o    = ram_we_q;
    assign ram_waddr_o = ram_waddr_q;
    assign ram_wdata_o = ram_wdata_q;
    assign state_o     = state_q;
    assign halted_o    = (state_q == HALT);
    assign bp_hit_o    = bp_hit_q;
    assign instr_cnt_o = instr_cnt_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: a tiny CPU model follows a next-PC table, and
// run outcomes are predicted by walking that table at program level.
module tb_cpu_run_controller;
    localparam int DW = 11;
    localparam int AW = 3;
    localparam int CW = 8;

    logic          clk, rst;
    logic          cmd_load, cmd_run, cmd_step, cmd_stop;
    logic          ld_valid, ld_ready;
    logic [DW-1:0] ld_data;
    logic [AW-1:0] pc, bp_addr;
    logic          bp_en;
    logic          pc_enable, ram_we, halted, bp_hit;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;
    logic [2:0]    state;
    logic [CW-1:0] instr_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    int nxt[8];

    logic          s_en, s_ready, s_we;
    logic [AW-1:0] s_waddr;
    logic [DW-1:0] s_wdata;

    cpu_run_controller #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(8), .CNT_W(CW)) dut (
        .clk_i(clk), .reset_i(rst),
        .cmd_load_i(cmd_load), .cmd_run_i(cmd_run), .cmd_step_i(cmd_step), .cmd_stop_i(cmd_stop),
        .ld_valid_i(ld_valid), .ld_data_i(ld_data), .ld_ready_o(ld_ready),
        .pc_i(pc), .bp_en_i(bp_en), .bp_addr_i(bp_addr),
        .pc_enable_o(pc_enable), .ram_we_o(ram_we), .ram_waddr_o(ram_waddr), .ram_wdata_o(ram_wdata),
        .state_o(state), .halted_o(halted), .bp_hit_o(bp_hit), .instr_cnt_o(instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample mid-cycle, then let the CPU model advance its PC on the edge.
    task automatic cycle();
        @(negedge clk);
        s_en = pc_enable; s_ready = ld_ready; s_we = ram_we;
        s_waddr = ram_waddr; s_wdata = ram_wdata;
        @(posedge clk);
        #1;
        if (s_en === 1'b1) pc = AW'(nxt[pc]);
    endtask

    // Program-level prediction: walk the next-PC table until a breakpoint or a self-jump.
    function automatic void model_run(input int start, output int e_state, output int e_cnt,
                                      output int e_pc, output int e_en, output bit e_bp);
        int p;
        bit first;
        p = start; first = 1'b1;
        e_state = 2; e_cnt = 0; e_en = 0; e_bp = 1'b0;
        for (int g = 0; g < 64; g++) begin
            if (bp_en && p == int'(bp_addr) && !first) begin
                e_state = 0; e_bp = 1'b1; e_en = e_cnt;
                break;
            end
            first = 1'b0;
            e_cnt++;
            if (nxt[p] == p) begin
                e_state = 4; e_en = e_cnt + 1;
                break;
            end
            p = nxt[p];
        end
        e_pc = p;
        if (e_cnt > 255) e_cnt = 255;
    endfunction

    // mode 0: valid held high, 1: toggling 1,0,1,0, 2: random valid and random words
    task automatic do_load(input int mode);
        logic [DW-1:0] w[8];
        int acc, guard, paddr;
        bit pend;
        logic [DW-1:0] pdata;
        for (int i = 0; i < 8; i++) w[i] = (mode == 2) ? DW'($urandom) : DW'(32'h101 + i);
        cmd_load = 1'b1; cycle(); cmd_load = 1'b0;
        check("load_enter_state", state, 1);
        acc = 0; guard = 0; pend = 1'b0; paddr = 0; pdata = '0;
        while (acc < 8 && guard < 100) begin
            ld_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (guard % 2 == 0) : 1'($urandom);
            ld_data  = w[acc];
            cycle();
            check("load_ready", s_ready, 1);
            check("load_we", s_we, pend);
            if (pend) begin
                check("load_waddr", s_waddr, paddr);
                check("load_wdata", s_wdata, pdata);
            end
            pend = ld_valid;
            if (ld_valid) begin paddr = acc; pdata = w[acc]; acc++; end
            guard++;
        end
        ld_valid = 1'b0;
        check("load_all_accepted", acc, 8);
        check("load_exit_state", state, 0);
        cycle();
        check("load_ready_dropped", s_ready, 0);
        check("load_last_we", s_we, 1);
        check("load_last_waddr", s_waddr, 7);
        check("load_last_wdata", s_wdata, w[7]);
        cycle();
        check("load_we_idle", s_we, 0);
        $display("load mode=%0d words=8 cycles=%0d", mode, guard);
    endtask

    task automatic do_run(input int start, output bit was_bp);
        int e_state, e_cnt, e_pc, e_en, en_cnt, n;
        bit e_bp;
        pc = AW'(start);
        model_run(start, e_state, e_cnt, e_pc, e_en, e_bp);
        cmd_run = 1'b1; cycle(); cmd_run = 1'b0;
        check("run_enter_state", state, 2);
        check("run_bp_cleared", bp_hit, 0);
        check("run_cnt_cleared", instr_cnt, 0);
        en_cnt = 0; n = 0;
        while (state == 3'd2 && n < 100) begin
            cycle();
            if (s_en === 1'b1) en_cnt++;
            n++;
        end
        check("run_end_state", state, e_state);
        check("run_halted", halted, (e_state == 4));
        check("run_bp_hit", bp_hit, e_bp);
        check("run_instr_cnt", instr_cnt, e_cnt);
        check("run_final_pc", pc, e_pc);
        check("run_enable_cycles", en_cnt, e_en);
        cycle();
        check("run_enable_off", s_en, 0);
        was_bp = e_bp;
        $display("run start=%0d bp_en=%0d bp=%0d -> state=%0d cnt=%0d pc=%0d",
                 start, bp_en, bp_addr, state, instr_cnt, pc);
    endtask

    initial begin
        bit was_bp;
        int start, exp_pc;
        logic [DW-1:0] wa, wb;
        rst = 1'b0; cmd_load = 0; cmd_run = 0; cmd_step = 0; cmd_stop = 0;
        ld_valid = 0; ld_data = '0; pc = '0; bp_en = 0; bp_addr = '0;
        for (int i = 0; i < 8; i++) nxt[i] = i;
        #1 rst = 1'b1;
        #1;
        check("rst_state", state, 0);
        check("rst_pc_enable", pc_enable, 0);
        check("rst_ld_ready", ld_ready, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_waddr", ram_waddr, 0);
        check("rst_wdata", ram_wdata, 0);
        check("rst_bp_hit", bp_hit, 0);
        check("rst_instr_cnt", instr_cnt, 0);
        check("rst_halted", halted, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        do_load(0);
        do_load(1);
        do_load(2);

        // 0,1,2,3 then a self-jump at 3
        for (int i = 0; i < 8; i++) nxt[i] = (i < 3) ? i + 1 : i;
        bp_en = 1'b0;
        do_run(0, was_bp);
        check("halt_cnt_is_4", instr_cnt, 4);
        do_run(int'(pc), was_bp);
        check("rehalt_cnt_is_1", instr_cnt, 1);

        bp_en = 1'b1; bp_addr = 3'd2;
        do_run(0, was_bp);
        check("bp_stop_pc", pc, 2);
        do_run(int'(pc), was_bp);
        check("bp_resume_past", pc, 3);

        repeat (6) begin
            for (int i = 0; i < 8; i++) nxt[i] = $urandom_range(7, i);
            bp_en = 1'($urandom);
            bp_addr = AW'($urandom);
            start = $urandom_range(7, 0);
            do_run(start, was_bp);
            if (was_bp) do_run(int'(pc), was_bp);
        end

        cmd_stop = 1'b1; cycle(); cmd_stop = 1'b0;
        check("stop_to_idle", state, 0);

        // Steps ignore a breakpoint sitting on the next PC
        for (int i = 0; i < 8; i++) nxt[i] = (i + 1) % 8;
        for (int k = 0; k < 3; k++) begin
            bp_en = 1'b1; bp_addr = AW'(int'(pc) + 1);
            exp_pc = (int'(pc) + 1) % 8;
            cmd_step = 1'b1; cycle(); cmd_step = 1'b0;
            check("step_enter_state", state, 3);
            check("step_cmd_cycle_en", s_en, 0);
            cycle();
            check("step_pulse", s_en, 1);
            check("step_back_idle", state, 0);
            check("step_cnt", instr_cnt, 1);
            check("step_pc", pc, exp_pc);
            cycle();
            check("step_pulse_single", s_en, 0);
            $display("step %0d pc=%0d cnt=%0d", k, pc, instr_cnt);
        end

        bp_en = 1'b0;
        cmd_run = 1'b1; cycle(); cmd_run = 1'b0;
        repeat (300) cycle();
        check("sat_state_run", state, 2);
        check("sat_cnt", instr_cnt, 255);
        cmd_stop = 1'b1; cycle(); cmd_stop = 1'b0;
        check("sat_stop_state", state, 0);
        cycle();
        check("sat_stop_en_off", s_en, 0);
        $display("saturating run stopped cnt=%0d", instr_cnt);

        cmd_load = 1'b1; cmd_stop = 1'b1; cycle(); cmd_load = 1'b0; cmd_stop = 1'b0;
        check("load_stop_same_cycle", state, 0);
        cycle();
        check("load_stop_ready", s_ready, 0);

        wa = DW'($urandom); wb = DW'($urandom);
        cmd_load = 1'b1; cycle(); cmd_load = 1'b0;
        ld_valid = 1'b1; ld_data = wa; cycle();
        ld_data = wb; cmd_stop = 1'b1; cycle(); cmd_stop = 1'b0; ld_valid = 1'b0;
        check("stop_load_state", state, 0);
        cycle();
        check("stop_load_we", s_we, 1);
        check("stop_load_waddr", s_waddr, 1);
        check("stop_load_wdata", s_wdata, wb);
        $display("load aborted after 2 words");

        cmd_load = 1'b1; cycle(); cmd_load = 1'b0;
        ld_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin ld_data = DW'($urandom); cycle(); end
        ld_valid = 1'b0;
        check("pre_reset_we", ram_we, 1);
        rst = 1'b1;
        #1;
        check("mid_reset_we", ram_we, 0);
        check("mid_reset_state", state, 0);
        check("mid_reset_ready", ld_ready, 0);
        check("mid_reset_waddr", ram_waddr, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        cycle();
        check("post_reset_we", s_we, 0);
        check("post_reset_state", state, 0);
        $display("reset during load after 3 accepts");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
